// File: rtl/checker_pkg.sv
// checker_pkg: shared state, record and counter definitions for commit_checker
package checker_pkg;
  localparam int CNT_W = 16;
  typedef enum logic {RUN, HALT} chk_state_t;
  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } commit_t;
endpackage

// File: rtl/commit_fifo.sv
// commit_fifo: synchronous FIFO holding one commit stream
// ports: clk/rst (async, active-high)/clr (sync), push/din in, pop in, head/full/empty out
module commit_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic wr_en;
  assign empty = wr_q == rd_q;
  assign full  = wr_q == {~rd_q[AW], rd_q[AW-1:0]};
  assign head  = mem[rd_q[AW-1:0]];
  // a full FIFO still takes a push when its head leaves on the same edge
  always_comb begin
    wr_en = push && (!full || pop);
    wr_d  = clr ? '0 : wr_q + (AW+1)'(wr_en);
    rd_d  = clr ? '0 : rd_q + (AW+1)'(pop && !empty);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  always_ff @(posedge clk)
    if (wr_en && !clr) mem[wr_q[AW-1:0]] <= din;
endmodule

// File: rtl/commit_checker.sv
// commit_checker: in-order scoreboard comparing RTL and model register write-back streams
// ports: Clock/Reset (async, active-high)/Clear (sync); Model*/Rtl* commit inputs;
// Match/Mismatch pulses, saturating counts, FirstErr* capture, sticky Overflow/Timeout, Halted
module commit_checker import checker_pkg::*; #(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 5,
  parameter int DEPTH         = 8,
  parameter int TIMEOUT       = 64,
  parameter bit STOP_ON_ERROR = 1,
  parameter bit IGNORE_R0     = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Clear,
  input  logic              ModelValid,
  input  logic [ADDR_W-1:0] ModelAddr,
  input  logic [DATA_W-1:0] ModelData,
  input  logic              RtlValid,
  input  logic [ADDR_W-1:0] RtlAddr,
  input  logic [DATA_W-1:0] RtlData,
  output logic              Match,
  output logic              Mismatch,
  output logic [CNT_W-1:0]  MatchCount,
  output logic [CNT_W-1:0]  MismatchCount,
  output logic [ADDR_W-1:0] FirstErrAddr,
  output logic [DATA_W-1:0] FirstErrExp,
  output logic [DATA_W-1:0] FirstErrGot,
  output logic              Overflow,
  output logic              Timeout,
  output logic              Halted
);
  localparam int W  = ADDR_W + DATA_W;
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef struct packed {
    chk_state_t        state;
    logic [TW-1:0]     skew;
    logic              match;
    logic              mismatch;
    logic [CNT_W-1:0]  match_cnt;
    logic [CNT_W-1:0]  mismatch_cnt;
    logic [ADDR_W-1:0] err_addr;
    logic [DATA_W-1:0] err_exp;
    logic [DATA_W-1:0] err_got;
    logic              overflow;
    logic              timeout;
  } regs_t;
  regs_t st_q, st_d;
  logic m_push, r_push, m_full, r_full, m_empty, r_empty, pop, same, one_side;
  logic [W-1:0] m_head, r_head;
  assign m_push = ModelValid && !(IGNORE_R0 && ModelAddr == '0);
  assign r_push = RtlValid && !(IGNORE_R0 && RtlAddr == '0);
  commit_fifo #(.W(W), .DEPTH(DEPTH)) u_model_fifo (
    .clk(Clock), .rst(Reset), .clr(Clear), .push(m_push), .pop(pop),
    .din({ModelAddr, ModelData}), .head(m_head), .full(m_full), .empty(m_empty)
  );
  commit_fifo #(.W(W), .DEPTH(DEPTH)) u_rtl_fifo (
    .clk(Clock), .rst(Reset), .clr(Clear), .push(r_push), .pop(pop),
    .din({RtlAddr, RtlData}), .head(r_head), .full(r_full), .empty(r_empty)
  );
  // mismatch_cnt==0 doubles as "no error captured yet" since it never wraps back to 0
  always_comb begin
    pop               = st_q.state == RUN && !m_empty && !r_empty;
    same              = m_head == r_head;
    one_side          = st_q.state == RUN && (m_empty != r_empty);
    st_d              = st_q;
    st_d.match        = pop && same;
    st_d.mismatch     = pop && !same;
    st_d.skew         = one_side ? st_q.skew + TW'(1) : '0;
    st_d.match_cnt    = st_q.match_cnt + CNT_W'(st_d.match && st_q.match_cnt != '1);
    st_d.mismatch_cnt = st_q.mismatch_cnt + CNT_W'(st_d.mismatch && st_q.mismatch_cnt != '1);
    if (st_d.mismatch && st_q.mismatch_cnt == '0) begin
      st_d.err_addr = m_head[W-1:DATA_W];
      st_d.err_exp  = m_head[DATA_W-1:0];
      st_d.err_got  = r_head[DATA_W-1:0];
    end
    st_d.overflow = st_q.overflow || (m_push && m_full && !pop) || (r_push && r_full && !pop);
    st_d.timeout  = st_q.timeout || st_d.skew == TW'(TIMEOUT);
    st_d.state    = (st_d.timeout || (STOP_ON_ERROR && st_d.mismatch)) ? HALT : st_q.state;
    if (Clear) st_d = '0;
  end
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) st_q <= '0;
    else st_q <= st_d;
  assign Match         = st_q.match;
  assign Mismatch      = st_q.mismatch;
  assign MatchCount    = st_q.match_cnt;
  assign MismatchCount = st_q.mismatch_cnt;
  assign FirstErrAddr  = st_q.err_addr;
  assign FirstErrExp   = st_q.err_exp;
  assign FirstErrGot   = st_q.err_got;
  assign Overflow      = st_q.overflow;
  assign Timeout       = st_q.timeout;
  assign Halted        = st_q.state == HALT;
endmodule

// File: tb/tb_commit_checker.sv
// tb_commit_checker: directed plus randomized checks of commit_checker against a queue-based model
module tb_commit_checker;
  localparam int DW = 32, AW = 5, DEPTH = 8, TIMEOUT = 64;
  localparam int EW = AW + DW;
  logic Clock = 0, Reset = 1, Clear = 0, ModelValid = 0, RtlValid = 0;
  logic [AW-1:0] ModelAddr = '0, RtlAddr = '0;
  logic [DW-1:0] ModelData = '0, RtlData = '0;
  logic Match, Mismatch, Overflow, Timeout, Halted;
  logic [15:0] MatchCount, MismatchCount;
  logic [AW-1:0] FirstErrAddr;
  logic [DW-1:0] FirstErrExp, FirstErrGot;
  int errors = 0, checks = 0;
  always #5 Clock = ~Clock;
  commit_checker #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT),
    .STOP_ON_ERROR(1'b1), .IGNORE_R0(1'b1)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Clear(Clear),
    .ModelValid(ModelValid), .ModelAddr(ModelAddr), .ModelData(ModelData),
    .RtlValid(RtlValid), .RtlAddr(RtlAddr), .RtlData(RtlData),
    .Match(Match), .Mismatch(Mismatch), .MatchCount(MatchCount), .MismatchCount(MismatchCount),
    .FirstErrAddr(FirstErrAddr), .FirstErrExp(FirstErrExp), .FirstErrGot(FirstErrGot),
    .Overflow(Overflow), .Timeout(Timeout), .Halted(Halted)
  );
  logic [EW-1:0] mq[$], rq[$];
  bit e_halt, e_match, e_mis, e_ovf, e_to;
  int e_mcnt, e_xcnt, e_timer;
  logic [AW-1:0] e_faddr;
  logic [DW-1:0] e_fexp, e_fgot;
  task automatic model_reset();
    mq.delete(); rq.delete();
    e_halt = 0; e_match = 0; e_mis = 0; e_ovf = 0; e_to = 0;
    e_mcnt = 0; e_xcnt = 0; e_timer = 0;
    e_faddr = '0; e_fexp = '0; e_fgot = '0;
  endtask
  task automatic model_step();
    logic [EW-1:0] a, b;
    bit both, one;
    both = mq.size() > 0 && rq.size() > 0;
    one = (mq.size() > 0) != (rq.size() > 0);
    e_match = 0;
    e_mis = 0;
    if (!e_halt && both) begin
      a = mq.pop_front();
      b = rq.pop_front();
      if (a == b) begin
        e_match = 1;
        if (e_mcnt < 65535) e_mcnt++;
      end else begin
        e_mis = 1;
        if (e_xcnt == 0) begin
          e_faddr = a[EW-1:DW];
          e_fexp = a[DW-1:0];
          e_fgot = b[DW-1:0];
        end
        if (e_xcnt < 65535) e_xcnt++;
      end
    end
    if (ModelValid && ModelAddr != 0) begin
      if (mq.size() < DEPTH) mq.push_back({ModelAddr, ModelData});
      else e_ovf = 1;
    end
    if (RtlValid && RtlAddr != 0) begin
      if (rq.size() < DEPTH) rq.push_back({RtlAddr, RtlData});
      else e_ovf = 1;
    end
    e_timer = (!e_halt && one) ? e_timer + 1 : 0;
    if (e_timer == TIMEOUT) e_to = 1;
    if (e_to || e_mis) e_halt = 1;
  endtask
  always @(posedge Clock)
    if (Reset || Clear) model_reset();
    else model_step();
  task automatic chk(string n, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", n, got, exp, $time);
    end
  endtask
  always @(negedge Clock)
    if (!Reset) begin
      chk("match", 64'(Match), 64'(e_match));
      chk("mismatch", 64'(Mismatch), 64'(e_mis));
      chk("match_count", 64'(MatchCount), 64'(e_mcnt));
      chk("mismatch_count", 64'(MismatchCount), 64'(e_xcnt));
      chk("first_addr", 64'(FirstErrAddr), 64'(e_faddr));
      chk("first_exp", 64'(FirstErrExp), 64'(e_fexp));
      chk("first_got", 64'(FirstErrGot), 64'(e_fgot));
      chk("overflow", 64'(Overflow), 64'(e_ovf));
      chk("timeout", 64'(Timeout), 64'(e_to));
      chk("halted", 64'(Halted), 64'(e_halt));
    end
  task automatic cyc(bit mv, logic [AW-1:0] ma, logic [DW-1:0] md, bit rv, logic [AW-1:0] ra, logic [DW-1:0] rd);
    ModelValid = mv; ModelAddr = ma; ModelData = md;
    RtlValid = rv; RtlAddr = ra; RtlData = rd;
    @(negedge Clock);
    ModelValid = 0;
    RtlValid = 0;
  endtask
  task automatic idle(int n);
    repeat (n) cyc(0, '0, '0, 0, '0, '0);
  endtask
  task automatic do_clear();
    Clear = 1;
    @(negedge Clock);
    Clear = 0;
  endtask
  task automatic rand_phase(int n);
    logic [EW-1:0] pm[$], pr[$], item, mi, ri;
    bit mv, rv;
    for (int c = 0; c < n; c++) begin
      if (c % 250 == 249 || (e_halt && $urandom_range(0, 3) == 0)) begin
        do_clear();
        pm.delete(); pr.delete();
        continue;
      end
      if (c == 1500) begin
        Reset = 1;
        @(negedge Clock);
        Reset = 0;
        pm.delete(); pr.delete();
        continue;
      end
      if ($urandom_range(0, 1) == 1) begin
        item = {AW'($urandom_range(0, 31)), DW'($urandom)};
        pm.push_back(item);
        pr.push_back(($urandom_range(0, 59) == 0) ? item ^ EW'(1) : item);
      end
      mv = pm.size() > 0 && $urandom_range(0, 2) != 0;
      rv = pr.size() > 0 && $urandom_range(0, 2) != 0;
      mi = mv ? pm.pop_front() : '0;
      ri = rv ? pr.pop_front() : '0;
      cyc(mv, mi[EW-1:DW], mi[DW-1:0], rv, ri[EW-1:DW], ri[DW-1:0]);
    end
  endtask
  initial begin
    repeat (2) @(negedge Clock);
    Reset = 0;
    chk("rst_match_count", 64'(MatchCount), 0);
    chk("rst_halted", 64'(Halted), 0);
    chk("rst_overflow", 64'(Overflow), 0);
    cyc(1, 1, 'h11, 1, 1, 'h11);
    chk("ls_no_early_match", 64'(Match), 0);
    cyc(1, 2, 'h22, 1, 2, 'h22);
    chk("ls_match_two_cycles", 64'(Match), 1);
    cyc(1, 3, 'h33, 1, 3, 'h33);
    cyc(1, 4, 'h44, 1, 4, 'h44);
    idle(3);
    chk("ls_match_count", 64'(MatchCount), 4);
    chk("ls_mismatch_count", 64'(MismatchCount), 0);
    do_clear();
    cyc(1, 5, 'hA5, 0, '0, '0);
    idle(5);
    cyc(0, '0, '0, 1, 5, 'hA5);
    chk("skew_not_yet", 64'(Match), 0);
    idle(1);
    chk("skew_match", 64'(Match), 1);
    chk("skew_no_timeout", 64'(Timeout), 0);
    chk("skew_count", 64'(MatchCount), 1);
    do_clear();
    cyc(1, 7, 'h1234, 1, 7, 'h1235);
    idle(1);
    chk("mis_pulse", 64'(Mismatch), 1);
    chk("mis_addr", 64'(FirstErrAddr), 7);
    chk("mis_exp", 64'(FirstErrExp), 'h1234);
    chk("mis_got", 64'(FirstErrGot), 'h1235);
    chk("mis_halted", 64'(Halted), 1);
    cyc(1, 3, 'h55, 1, 3, 'h55);
    idle(3);
    chk("halt_no_match", 64'(MatchCount), 0);
    chk("halt_mis_count", 64'(MismatchCount), 1);
    do_clear();
    for (int i = 1; i <= 9; i++) begin
      cyc(1, AW'(i), DW'(i * 16), 0, '0, '0);
      if (i == 8) chk("ovf_not_yet", 64'(Overflow), 0);
    end
    chk("ovf_set", 64'(Overflow), 1);
    for (int i = 1; i <= 8; i++) cyc(0, '0, '0, 1, AW'(i), DW'(i * 16));
    idle(3);
    chk("ovf_kept_eight", 64'(MatchCount), 8);
    chk("ovf_no_mismatch", 64'(MismatchCount), 0);
    chk("ovf_running", 64'(Halted), 0);
    do_clear();
    cyc(0, '0, '0, 1, 1, 'h99);
    idle(63);
    chk("to_not_yet", 64'(Timeout), 0);
    idle(1);
    chk("to_set", 64'(Timeout), 1);
    chk("to_halted", 64'(Halted), 1);
    do_clear();
    chk("clr_halted", 64'(Halted), 0);
    chk("clr_timeout", 64'(Timeout), 0);
    chk("clr_overflow", 64'(Overflow), 0);
    chk("clr_counts", 64'({MatchCount, MismatchCount}), 0);
    chk("clr_first", 64'({FirstErrAddr, FirstErrExp, FirstErrGot}), 0);
    cyc(1, 0, 'hAA, 1, 0, 'hBB);
    idle(1);
    chk("r0_no_mismatch", 64'(Mismatch), 0);
    chk("r0_no_match", 64'(Match), 0);
    idle(2);
    chk("r0_counts", 64'({MatchCount, MismatchCount}), 0);
    rand_phase(3000);
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
